// File: rtl/cache_definitions_pkg.sv
// Shared cache/memory transaction types plus the arbiter state encoding.
// Imported by the memory arbiter and its round-robin picker.
package cache_definitions_pkg;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_t;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_t;

  localparam int NUM_REQUESTERS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Index of the set bit in a two-requester one-hot vector.
  function automatic logic onehot_to_idx(input logic [NUM_REQUESTERS-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_picker
  import cache_definitions_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      last_grant,
  output logic [NUM_REQUESTERS-1:0] winner
);

  // Winner selection from the current request vector and previous owner.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_grant ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data caches onto one main-memory port.
// The granted request is frozen until memory answers or the timeout forces completion.
module mem_arbiter
  import cache_definitions_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  mem_req_t   req0,
  output mem_data_t  rsp0,
  input  mem_req_t   req1,
  output mem_data_t  rsp1,
  output mem_req_t   mem_req,
  input  mem_data_t  mem_data,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  arb_state_t                  state_r;
  mem_req_t                    mem_req_r;
  logic [NUM_REQUESTERS-1:0]   grant_r;
  logic [CNT_W-1:0]            cnt_r;
  logic                        last_grant_r;
  logic [NUM_REQUESTERS-1:0]   winner_s;
  logic                        timeout_hit_s;
  logic                        done_s;

  rr_picker u_rr_picker (
    .req        ({req1.valid, req0.valid}),
    .last_grant (last_grant_r),
    .winner     (winner_s)
  );

  // A real ready in the last allowed cycle beats the timeout.
  assign timeout_hit_s = (state_r == GRANT) && !mem_data.ready && (cnt_r == CNT_LAST);
  assign done_s        = (state_r == GRANT) && (mem_data.ready || timeout_hit_s);

  assign mem_req = mem_req_r;
  assign grant   = grant_r;

  // Arbitration FSM with the frozen memory request, owner and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      mem_req_r    <= '0;
      grant_r      <= 2'b00;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (winner_s != 2'b00) begin
            state_r   <= GRANT;
            grant_r   <= winner_s;
            mem_req_r <= winner_s[0] ? req0 : req1;
            cnt_r     <= '0;
          end else begin
            state_r         <= IDLE;
            grant_r         <= 2'b00;
            mem_req_r.valid <= 1'b0;
          end
        end
        GRANT: begin
          if (done_s) begin
            state_r         <= DRAIN;
            mem_req_r.valid <= 1'b0;
            grant_r         <= 2'b00;
            last_grant_r    <= onehot_to_idx(grant_r);
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        // A memory that keeps ready high must not complete a second time.
        DRAIN: begin
          if (!mem_data.ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= '0;
          grant_r   <= 2'b00;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  // Response steering: data fans out to both caches, ready only to the owner.
  always_comb begin
    rsp0        = '0;
    rsp1        = '0;
    timeout_err = 1'b0;
    if (state_r == GRANT) begin
      rsp0.data = mem_data.data;
      rsp1.data = mem_data.data;
      if (timeout_hit_s) begin
        timeout_err = 1'b1;
        if (grant_r[0]) begin
          rsp0.data  = '0;
          rsp0.ready = 1'b1;
        end else begin
          rsp1.data  = '0;
          rsp1.ready = 1'b1;
        end
      end else begin
        rsp0.ready = grant_r[0] & mem_data.ready;
        rsp1.ready = grant_r[1] & mem_data.ready;
      end
    end else begin
      rsp0        = '0;
      rsp1        = '0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in GRANT waiting for mem_data.ready before forced completion.
REQ-002 clk  in  1  free-running clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0  in  mem_req_t  requester 0 (instruction cache) memory request: addr, data, rw, valid.
REQ-005 rsp0  out  mem_data_t  response to requester 0: data, ready.
REQ-006 req1  in  mem_req_t  requester 1 (data cache) memory request.
REQ-007 rsp1  out  mem_data_t  response to requester 1.
REQ-008 mem_req  out  mem_req_t  request to the shared main memory.
REQ-009 mem_data  in  mem_data_t  main memory response.
REQ-010 grant  out  2  one-hot owner of the memory port; 2'b00 when idle.
REQ-011 timeout_err  out  1  one-cycle pulse when a transaction is force-completed.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and DRAIN.
REQ-013 In IDLE with no reqN.valid set, the FSM SHALL stay in IDLE, with mem_req.valid=0 and grant=2'b00.
REQ-014 In IDLE with exactly one reqN.valid set, the FSM SHALL grant that requester and enter GRANT on the next edge.
REQ-015 In IDLE with both valid, the FSM SHALL grant the requester not served last (round-robin), using a last_grant register.
REQ-016 On the grant edge, the block SHALL register mem_req from the winner's request, so mem_req.valid=1 exactly one cycle after the request is sampled.
REQ-017 mem_req SHALL hold constant throughout GRANT; later changes on reqN SHALL be ignored.
REQ-018 In GRANT, mem_data.data SHALL be driven to both rsp0.data and rsp1.data combinationally.
REQ-019 rspN.ready SHALL equal mem_data.ready only for the granted requester; the other requester's ready SHALL be 0.
REQ-020 When mem_data.ready=1 in GRANT, the FSM SHALL clear mem_req.valid, update last_grant and enter DRAIN on the next edge.
REQ-021 In DRAIN, rsp0.ready and rsp1.ready SHALL be 0, and the FSM SHALL return to IDLE on the first cycle with mem_data.ready=0.
REQ-022 DRAIN SHALL absorb memories that hold ready for several cycles, so a single completion is never seen twice.
REQ-023 A saturating cycle counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 with no ready, the block SHALL, for one cycle, drive the granted rspN.ready=1 with rspN.data=0 and pulse timeout_err.
REQ-025 After a timeout completion, the FSM SHALL enter DRAIN and last_grant SHALL update.
REQ-026 If mem_data.ready and the timeout occur in the same cycle, ready SHALL win, with real data returned and no timeout_err pulse.
REQ-027 A requester SHALL hold valid until its rspN.ready; a request dropped before grant is simply not served.
REQ-028 Read and write (rw=1) transactions SHALL be handled identically; completion is signalled by ready.

Reset
REQ-029 On reset assertion, the block SHALL immediately set state=IDLE, mem_req to all-zero (valid=0), grant=2'b00, rsp0 and rsp1 to zero, timeout_err=0, counter=0 and last_grant=requester 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-GRANT SHALL abandon the transaction, and no response SHALL be issued after reset release.

Structure
REQ-031 The arb_state_t enumeration and the requester-count constant SHALL be added to cache_definitions_pkg; mem_req_t and mem_data_t SHALL be reused unchanged.
REQ-032 The round-robin pick logic SHALL be one sub-module, rr_picker (2 requests, last_grant in, one-hot winner out).

Verification
REQ-033 req0 read at 32'h0000_0FF0 alone, memory returns 128'h1234_ABCD_FFFF_DEAD with ready held 2 cycles -> mem_req.valid one cycle after the request, rsp0.ready asserted once with that data, rsp1.ready=0, back in IDLE after ready falls.
REQ-034 req0 and req1 assert in the same cycle after reset -> req0 served first, then req1; a second simultaneous pair -> req0 first again (last_grant=1).
REQ-035 req1 changes addr from 32'h0000_0FF0 to 32'h0000_1000 during GRANT -> mem_req.addr stays 32'h0000_0FF0 until completion.
REQ-036 Memory never raises ready, TIMEOUT_CYCLES=64 -> after 64 GRANT cycles, rsp0.ready=1 with data 0 and a single timeout_err pulse; the next request is served normally.
REQ-037 Reset pulse 3 cycles into GRANT -> all outputs zero immediately, and no rspN.ready occurs after release, even if memory then raises ready.
